// File: rtl/fc_mem_write.sv
// Streams 32-bit host words into the dual-port FC weight RAM. The low half of word k goes to
// port0[k] and the high half to port1[BASE1+k], both written in the same cycle.
module fc_mem_write #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 192,
  parameter int BASE1  = 192
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_in_valid,
  input  logic [2*DATA_W-1:0] i_in_data,
  output logic                o_in_ready,
  output logic                o_we0,
  output logic [ADDR_W-1:0]   o_addr0,
  output logic [DATA_W-1:0]   o_wdata0,
  output logic                o_we1,
  output logic [ADDR_W-1:0]   o_addr1,
  output logic [DATA_W-1:0]   o_wdata1,
  output logic                o_busy,
  output logic                o_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_BASE1 = ADDR_W'(BASE1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr0;
  logic [ADDR_W-1:0]   r_addr1;
  logic [DATA_W-1:0]   r_wdata0;
  logic [DATA_W-1:0]   r_wdata1;
  logic                w_accept;

  assign w_accept = i_in_valid && (r_state == S_LOAD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_addr0  <= '0;
      r_addr1  <= LP_BASE1;
      r_wdata0 <= '0;
      r_wdata1 <= '0;
    end else begin
      r_we <= w_accept;
      // addr/wdata hold their last values between accepts
      if (w_accept) begin
        r_addr0  <= r_count;
        r_addr1  <= LP_BASE1 + r_count;
        r_wdata0 <= i_in_data[DATA_W-1:0];
        r_wdata1 <= i_in_data[2*DATA_W-1:DATA_W];
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_count <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (r_count == LP_LAST) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_count <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready = (r_state == S_LOAD);
  assign o_busy     = (r_state == S_LOAD);
  assign o_done     = (r_state == S_DONE);
  assign o_we0      = r_we;
  assign o_we1      = r_we;
  assign o_addr0    = r_addr0;
  assign o_addr1    = r_addr1;
  assign o_wdata0   = r_wdata0;
  assign o_wdata1   = r_wdata1;

endmodule
